// File: rtl/grf_wport_arbiter.sv
// Arbitrates the single GRF write port between the W stage and a small FIFO of
// pending mult/div results, with a starvation counter that forces MD progress.
module grf_wport_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     md_valid,
  input  logic [ADDR_W-1:0]        md_addr,
  input  logic [DATA_W-1:0]        md_data,
  output logic                     md_ready,
  output logic                     wb_stall,
  output logic                     addr_sel,
  output logic                     grf_we,
  output logic [ADDR_W-1:0]        grf_addr,
  output logic [DATA_W-1:0]        grf_data,
  output logic [$clog2(DEPTH):0]   pending_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ST_W-1:0]   starve;

  logic ne;
  logic full;
  logic starve_hit;
  logic md_grant;
  logic push;
  logic store;
  logic pop;

  assign ne          = (count != '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign starve_hit  = (starve == ST_W'(STARVE_MAX));
  assign md_ready    = !full;
  assign pending_cnt = count;

  // Writes to $0 complete the handshake but are dropped before the FIFO.
  assign push     = md_valid && md_ready;
  assign store    = push && (md_addr != '0);
  assign md_grant = !reset && ne && (!wb_we || starve_hit);
  assign pop      = md_grant;

  always_comb begin
    addr_sel = 1'b1;
    grf_we   = 1'b0;
    grf_addr = wb_addr;
    grf_data = wb_data;
    wb_stall = 1'b0;
    if (reset) begin
      addr_sel = 1'b1;
    end else if (md_grant) begin
      addr_sel = 1'b0;
      grf_we   = 1'b1;
      grf_addr = fifo_addr[rd_ptr];
      grf_data = fifo_data[rd_ptr];
      wb_stall = wb_we;
    end else if (wb_we) begin
      grf_we = (wb_addr != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      fifo_addr[wr_ptr] <= md_addr;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (md_grant) begin
        starve <= '0;
      end else if (wb_we) begin
        if (!ne)              starve <= '0;
        else if (!starve_hit) starve <= starve + ST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && !ne)) else $error("grf_wport_arbiter: pop while empty");
      assert (!(store && full)) else $error("grf_wport_arbiter: push while full");
    end
  end

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed vector bench for grf_wport_arbiter: one record per cycle, plus a
// hand-written asynchronous reset sequence.
module tb_grf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_addr = '0;
  logic [31:0] md_data = '0;
  logic        md_ready, wb_stall, addr_sel, grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic [1:0]  pending_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  grf_wport_arbiter #(.ADDR_W(5), .DATA_W(32), .DEPTH(2), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data),
    .md_ready(md_ready), .wb_stall(wb_stall), .addr_sel(addr_sel),
    .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        rdy;
    logic        stl;
    logic        sel;
    logic        gwe;
    logic [4:0]  ga;
    logic [31:0] gd;
    logic [1:0]  cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t v [NV];

  function automatic vec_t mk(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic mv, logic [4:0] ma, logic [31:0] md,
                              logic rdy, logic stl, logic sel, logic gwe,
                              logic [4:0] ga, logic [31:0] gd, logic [1:0] cnt);
    vec_t r;
    r.rst = rst; r.we = we; r.wa = wa; r.wd = wd;
    r.mv = mv; r.ma = ma; r.md = md;
    r.rdy = rdy; r.stl = stl; r.sel = sel; r.gwe = gwe;
    r.ga = ga; r.gd = gd; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //         rst we wa wd      mv ma md        rdy stl sel gwe ga gd       cnt
    v[0]  = mk(1, 1, 5, 'hAA,   0, 0, 0,        1, 0, 1, 0, 0, 0,       0);
    v[1]  = mk(0, 0, 0, 0,      0, 0, 0,        1, 0, 1, 0, 0, 0,       0);
    v[2]  = mk(0, 0, 0, 0,      1, 8, 'h1234,   1, 0, 1, 0, 0, 0,       0);
    v[3]  = mk(0, 0, 0, 0,      0, 0, 0,        1, 0, 0, 1, 8, 'h1234,  1);
    v[4]  = mk(0, 0, 0, 0,      0, 0, 0,        1, 0, 1, 0, 0, 0,       0);
    v[5]  = mk(0, 0, 0, 0,      1, 0, 'h55,     1, 0, 1, 0, 0, 0,       0);
    v[6]  = mk(0, 0, 0, 0,      0, 0, 0,        1, 0, 1, 0, 0, 0,       0);
    v[7]  = mk(0, 1, 0, 'h77,   0, 0, 0,        1, 0, 1, 0, 0, 0,       0);
    v[8]  = mk(0, 1, 4, 'h44,   0, 0, 0,        1, 0, 1, 1, 4, 'h44,    0);
    v[9]  = mk(0, 1, 3, 'h33,   1, 9, 'h99,     1, 0, 1, 1, 3, 'h33,    0);
    v[10] = mk(0, 1, 3, 'h33,   0, 0, 0,        1, 0, 1, 1, 3, 'h33,    1);
    v[11] = mk(0, 1, 3, 'h33,   0, 0, 0,        1, 0, 1, 1, 3, 'h33,    1);
    v[12] = mk(0, 1, 3, 'h33,   0, 0, 0,        1, 0, 1, 1, 3, 'h33,    1);
    v[13] = mk(0, 1, 3, 'h33,   0, 0, 0,        1, 1, 0, 1, 9, 'h99,    1);
    v[14] = mk(0, 1, 3, 'h33,   0, 0, 0,        1, 0, 1, 1, 3, 'h33,    0);
    v[15] = mk(0, 1, 3, 'h33,   1, 10, 'hA0,    1, 0, 1, 1, 3, 'h33,    0);
    v[16] = mk(0, 1, 3, 'h33,   1, 11, 'hB0,    1, 0, 1, 1, 3, 'h33,    1);
    v[17] = mk(0, 1, 3, 'h33,   1, 12, 'hC0,    0, 0, 1, 1, 3, 'h33,    2);
    v[18] = mk(0, 1, 3, 'h33,   1, 12, 'hC0,    0, 0, 1, 1, 3, 'h33,    2);
    v[19] = mk(0, 1, 3, 'h33,   1, 12, 'hC0,    0, 1, 0, 1, 10, 'hA0,   2);
    v[20] = mk(0, 1, 3, 'h33,   1, 12, 'hC0,    1, 0, 1, 1, 3, 'h33,    1);
    v[21] = mk(0, 0, 0, 0,      0, 0, 0,        0, 0, 0, 1, 11, 'hB0,   2);
    v[22] = mk(0, 0, 0, 0,      0, 0, 0,        1, 0, 0, 1, 12, 'hC0,   1);
    v[23] = mk(0, 0, 0, 0,      1, 13, 'hD0,    1, 0, 1, 0, 0, 0,       0);
    v[24] = mk(0, 0, 0, 0,      1, 14, 'hE0,    1, 0, 0, 1, 13, 'hD0,   1);
    v[25] = mk(0, 0, 0, 0,      1, 15, 'hF0,    1, 0, 0, 1, 14, 'hE0,   1);
    v[26] = mk(0, 0, 0, 0,      1, 16, 'h10,    1, 0, 0, 1, 15, 'hF0,   1);
    v[27] = mk(0, 0, 0, 0,      1, 17, 'h11,    1, 0, 0, 1, 16, 'h10,   1);
    v[28] = mk(0, 0, 0, 0,      0, 0, 0,        1, 0, 0, 1, 17, 'h11,   1);
    v[29] = mk(0, 0, 0, 0,      0, 0, 0,        1, 0, 1, 0, 0, 0,       0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = v[i].rst; wb_we = v[i].we; wb_addr = v[i].wa; wb_data = v[i].wd;
      md_valid = v[i].mv; md_addr = v[i].ma; md_data = v[i].md;
      #1;
      chk("md_ready", i, 32'(md_ready), 32'(v[i].rdy));
      chk("wb_stall", i, 32'(wb_stall), 32'(v[i].stl));
      chk("addr_sel", i, 32'(addr_sel), 32'(v[i].sel));
      chk("grf_we", i, 32'(grf_we), 32'(v[i].gwe));
      chk("pending_cnt", i, 32'(pending_cnt), 32'(v[i].cnt));
      if (v[i].gwe) begin
        chk("grf_addr", i, 32'(grf_addr), 32'(v[i].ga));
        chk("grf_data", i, grf_data, v[i].gd);
      end
    end

    // Reset mid-operation with two entries queued behind a busy W stage.
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    md_valid = 1'b1; md_addr = 5'd20; md_data = 32'h200;
    @(negedge clk);
    md_addr = 5'd21; md_data = 32'h210;
    @(negedge clk);
    md_valid = 1'b0;
    #1;
    chk("rst_pre_cnt", 100, 32'(pending_cnt), 32'd2);
    chk("rst_pre_ready", 100, 32'(md_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_cnt", 101, 32'(pending_cnt), 32'd0);
    chk("rst_async_ready", 101, 32'(md_ready), 32'd1);
    chk("rst_async_we", 101, 32'(grf_we), 32'd0);
    chk("rst_async_stall", 101, 32'(wb_stall), 32'd0);
    chk("rst_async_sel", 101, 32'(addr_sel), 32'd1);
    @(negedge clk);
    reset = 1'b0; wb_we = 1'b0;
    #1;
    chk("rst_post_we", 102, 32'(grf_we), 32'd0);
    chk("rst_post_cnt", 102, 32'(pending_cnt), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_post2_we", 103, 32'(grf_we), 32'd0);
    chk("rst_post2_sel", 103, 32'(addr_sel), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
- Shares the single GRF write port between two requesters: the in-order pipeline W stage and the multi-cycle mult/div result channel (MD).
- MD results are buffered in a small FIFO.
- A starvation counter guarantees MD progress.
- Drives addr_sel for the 5-bit 2:1 write-address mux: sel=1 picks the W-stage address, sel=0 picks the MD FIFO head address. It also drives the final GRF write enable and data.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
DEPTH, 2, MD pending FIFO entries (power of 2, >=2)
STARVE_MAX, 3, max consecutive W grants while FIFO non-empty before MD is forced

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
wb_we  in  1  W-stage write request
wb_addr  in  ADDR_W  W-stage destination register
wb_data  in  DATA_W  W-stage write data
md_valid  in  1  MD result offered
md_addr  in  ADDR_W  MD destination register
md_data  in  DATA_W  MD result data
md_ready  out  1  FIFO can accept (= !full)
wb_stall  out  1  W-stage write not granted this cycle; pipeline must hold W
addr_sel  out  1  write-address mux select: 1 = wb_addr, 0 = FIFO head addr
grf_we  out  1  GRF write enable
grf_addr  out  ADDR_W  granted write address
grf_data  out  DATA_W  granted write data
pending_cnt  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, active-high):
  - FIFO emptied; rd/wr pointers 0; starve counter 0.
  - While reset is high, outputs are held at grf_we=0, wb_stall=0, addr_sel=1, md_ready=1, pending_cnt=0.
- Enqueue:
  - Triggered by md_valid & md_ready at the rising edge. Entry becomes visible as head the next cycle, so minimum MD latency is 1 cycle; there is no bypass.
  - md_addr==0: the handshake completes but nothing is stored.
- md_ready is computed from registered occupancy only. When full, md_ready=0 even if a pop happens the same cycle.
- Grant decision is combinational from registered state plus the current wb_we. Let ne = FIFO non-empty.
  - MD grant when ne & (!wb_we | starve==STARVE_MAX):
    - addr_sel=0; grf_addr/grf_data = head; grf_we=1.
    - Pop at edge; starve←0.
    - wb_stall = wb_we.
  - Else W grant when wb_we:
    - addr_sel=1; grf_addr=wb_addr; grf_data=wb_data; wb_stall=0.
    - grf_we = (wb_addr!=0).
    - starve←starve+1 if ne, else starve←0.
  - Else idle: grf_we=0, addr_sel=1, wb_stall=0; starve unchanged.
- The counter saturates at STARVE_MAX. After a forced MD grant the stalled W write wins the next cycle unless STARVE_MAX=0.
- Enqueue and pop in the same cycle are allowed when not full; occupancy is unchanged. Pointers wrap modulo DEPTH.
- A stalled W stage holds wb_we/addr/data stable. The arbiter does not latch them.
- The GRF is never written at address 0 (grf_we=0).
- Assert (sim only): no pop when empty; no push when full.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, assert reset → pending_cnt=0, md_ready=1, grf_we=0 immediately (asynchronous). After release, no stale write occurs.
- MD only: md_valid with addr=8, data=0x1234 at cycle 0 → cycle 1: addr_sel=0, grf_we=1, grf_addr=8, grf_data=0x1234; cycle 2: pending_cnt=0.
- Priority: FIFO holds addr=9 and wb_we=1 with addr=3 for 5 cycles (STARVE_MAX=3) → W granted cycles 0-2; cycle 3: MD granted, addr_sel=0, wb_stall=1; cycle 4: W granted with addr=3.
- Full: push 2 entries with wb_we held 1 → md_ready=0 and pending_cnt=2. An md_valid offered while full is not accepted. md_ready returns to 1 the cycle after the first pop.
- $0 handling: md_valid addr=0 → accepted, pending_cnt stays 0. wb_we addr=0 → grf_we=0, wb_stall=0.
- Simultaneous push/pop: occupancy 1, wb_we=0, md_valid=1 → head written, new entry stored, pending_cnt stays 1. Repeating for 4 cycles exercises pointer wrap; data must come out in order.
